// File: rtl/acess_pkg.sv
// Shared types and default widths for the access-control sequencer.
// Imported by the sequencer interface and the sequencer itself.
package acess_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CHECK,
    OPEN,
    LOCKOUT
  } acess_state_t;

  localparam int ACESS_ADDR_W = 3;
  localparam int ACESS_DATA_W = 8;

endpackage

// File: rtl/acess_seq_ctrl_if.sv
// Bundle of the keypad request, door status, ROM port and status signals
// around acess_seq_ctrl; the sequencer uses the slave view.
interface acess_seq_ctrl_if
  import acess_pkg::*;
#(
  parameter int ADDR_W    = ACESS_ADDR_W,
  parameter int DATA_W    = ACESS_DATA_W,
  parameter int MAX_TRIES = 3
);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  logic              start;
  logic [DATA_W-1:0] senha_digitada;
  logic              fechou;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              busy;
  logic              liberado;
  logic              negado;
  logic              bloqueado;
  logic [TRY_W-1:0]  tentativas;

  modport master (
    output start, senha_digitada, fechou, rom_data,
    input  rom_addr, busy, liberado, negado, bloqueado, tentativas
  );

  modport slave (
    input  start, senha_digitada, fechou, rom_data,
    output rom_addr, busy, liberado, negado, bloqueado, tentativas
  );

endinterface

// File: rtl/comparador.sv
// Word equality comparator used for the password-vs-ROM match test.
// Purely combinational; the caller registers the decision.
module comparador #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq
);

  logic [W-1:0] bit_eq;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      assign bit_eq[gi] = ~(a[gi] ^ b[gi]);
    end
  endgenerate

  assign eq = &bit_eq;

endmodule

// File: rtl/acess_seq_ctrl.sv
// Access-control sequencer: latches the typed password, scans the external ROM
// entry by entry, grants access or counts failures, and enforces a timed lockout.
module acess_seq_ctrl
  import acess_pkg::*;
#(
  parameter int ADDR_W      = ACESS_ADDR_W,
  parameter int DATA_W      = ACESS_DATA_W,
  parameter int N_ENTRIES   = 8,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 16
) (
  input logic             clk,
  input logic             rst,
  acess_seq_ctrl_if.slave bus
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int TMR_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_ENTRIES - 1);
  localparam logic [TRY_W-1:0]  TRY_MAX  = TRY_W'(MAX_TRIES);
  localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(LOCK_CYCLES - 1);

  acess_state_t      state_reg;
  logic [DATA_W-1:0] pw_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic [TMR_W-1:0]  timer_reg;
  logic [TRY_W-1:0]  tent_reg;
  logic              busy_reg;
  logic              liberado_reg;
  logic              negado_reg;
  logic              bloqueado_reg;

  logic              match;
  logic [TRY_W-1:0]  tent_next;

  comparador #(
    .W (DATA_W)
  ) u_cmp (
    .a  (bus.rom_data),
    .b  (pw_reg),
    .eq (match)
  );

  // Failure count saturates so it can never be seen above MAX_TRIES.
  assign tent_next = (tent_reg == TRY_MAX) ? TRY_MAX : tent_reg + TRY_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      pw_reg        <= '0;
      idx_reg       <= '0;
      timer_reg     <= '0;
      tent_reg      <= '0;
      busy_reg      <= 1'b0;
      liberado_reg  <= 1'b0;
      negado_reg    <= 1'b0;
      bloqueado_reg <= 1'b0;
    end else begin
      negado_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            pw_reg    <= bus.senha_digitada;
            idx_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= FETCH;
          end
        end

        // idx_reg doubles as the ROM address, so it is already on the bus here.
        FETCH: begin
          state_reg <= CHECK;
        end

        CHECK: begin
          if (match) begin
            tent_reg     <= '0;
            liberado_reg <= 1'b1;
            state_reg    <= OPEN;
          end else if (idx_reg != LAST_IDX) begin
            idx_reg   <= idx_reg + ADDR_W'(1);
            state_reg <= FETCH;
          end else begin
            negado_reg <= 1'b1;
            tent_reg   <= tent_next;
            if (tent_next == TRY_MAX) begin
              timer_reg     <= TMR_LOAD;
              bloqueado_reg <= 1'b1;
              state_reg     <= LOCKOUT;
            end else begin
              busy_reg  <= 1'b0;
              state_reg <= IDLE;
            end
          end
        end

        OPEN: begin
          if (bus.fechou) begin
            liberado_reg <= 1'b0;
            busy_reg     <= 1'b0;
            state_reg    <= IDLE;
          end
        end

        LOCKOUT: begin
          if (timer_reg == '0) begin
            tent_reg      <= '0;
            bloqueado_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end else begin
            timer_reg <= timer_reg - TMR_W'(1);
          end
        end

        default: begin
          liberado_reg  <= 1'b0;
          bloqueado_reg <= 1'b0;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign bus.rom_addr   = idx_reg;
  assign bus.busy       = busy_reg;
  assign bus.liberado   = liberado_reg;
  assign bus.negado     = negado_reg;
  assign bus.bloqueado  = bloqueado_reg;
  assign bus.tentativas = tent_reg;

endmodule

// File: tb/tb_acess_seq_ctrl.sv
// Directed bench for acess_seq_ctrl with a registered ROM model and a queue of
// predicted scan outcomes that is popped as each scan completes.
module tb_acess_seq_ctrl;

  localparam int K_NONE  = 0;
  localparam int K_GRANT = 1;
  localparam int K_DENY  = 2;
  localparam int K_LOCK  = 3;

  typedef struct {
    int kind;
    int cyc;
    int tent;
    int busy;
    int lock;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rom [0:7];
  exp_t       sb [$];
  int         n_cmp = 0;
  int         n_mis = 0;
  int         m_tries = 0;

  always #5 clk = ~clk;

  acess_seq_ctrl_if #(.ADDR_W(3), .DATA_W(8), .MAX_TRIES(3)) bus ();

  acess_seq_ctrl #(
    .ADDR_W      (3),
    .DATA_W      (8),
    .N_ENTRIES   (8),
    .MAX_TRIES   (3),
    .LOCK_CYCLES (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous ROM, one cycle of read latency.
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t predict(input logic [7:0] pw);
    exp_t e;
    e.kind = K_NONE;
    e.cyc  = 0;
    for (int i = 0; i < 8; i++) begin
      if (e.kind == K_NONE && rom[i] == pw) begin
        e.kind = K_GRANT;
        e.cyc  = 2 * i + 3;
      end
    end
    if (e.kind == K_GRANT) begin
      m_tries = 0;
      e.tent  = 0;
      e.busy  = 1;
      e.lock  = 0;
    end else begin
      m_tries++;
      e.cyc  = 17;
      e.tent = m_tries;
      if (m_tries == 3) begin
        e.kind  = K_LOCK;
        e.busy  = 1;
        e.lock  = 1;
        m_tries = 0;
      end else begin
        e.kind = K_DENY;
        e.busy = 0;
        e.lock = 0;
      end
    end
    return e;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_rom_addr"}, 32'(bus.rom_addr), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_liberado"}, 32'(bus.liberado), 0);
    check({tag, "_negado"}, 32'(bus.negado), 0);
    check({tag, "_bloqueado"}, 32'(bus.bloqueado), 0);
    check({tag, "_tentativas"}, 32'(bus.tentativas), 0);
  endtask

  // Starts a scan from a negedge in IDLE; optional poke drives start+fechou
  // with a different password for two cycles mid-scan. Returns in the outcome cycle.
  task automatic run_scan(input logic [7:0] pw, input int poke_at, input string tag);
    exp_t e;
    int   c;
    int   kind;
    int   hit;
    bit   pk;
    sb.push_back(predict(pw));
    bus.senha_digitada = pw;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    c    = 1;
    kind = K_NONE;
    hit  = 0;
    while (kind == K_NONE && c < 40) begin
      if (bus.liberado === 1'b1) begin
        kind = K_GRANT;
        hit  = c;
      end else if (bus.negado === 1'b1) begin
        kind = (bus.bloqueado === 1'b1) ? K_LOCK : K_DENY;
        hit  = c;
      end else begin
        if (c % 2 == 1) check({tag, "_rom_addr_seq"}, 32'(bus.rom_addr), 32'((c - 1) / 2));
        pk = (poke_at != 0) && (c == poke_at || c == poke_at + 1);
        bus.start = pk;
        bus.fechou = pk;
        bus.senha_digitada = pk ? 8'h11 : pw;
        @(negedge clk);
        c++;
      end
    end
    bus.start  = 1'b0;
    bus.fechou = 1'b0;
    e = sb.pop_front();
    $display("scan %s pw=%02h: kind=%0d cycle=%0d tentativas=%0d", tag, pw, kind, hit, bus.tentativas);
    check({tag, "_kind"}, 32'(kind), 32'(e.kind));
    check({tag, "_cycle"}, 32'(hit), 32'(e.cyc));
    check({tag, "_tentativas"}, 32'(bus.tentativas), 32'(e.tent));
    check({tag, "_busy"}, 32'(bus.busy), 32'(e.busy));
    check({tag, "_bloqueado"}, 32'(bus.bloqueado), 32'(e.lock));
  endtask

  task automatic close_door(input string tag);
    @(negedge clk);
    check({tag, "_open_hold"}, 32'(bus.liberado), 1);
    bus.start = 1'b1;
    bus.senha_digitada = 8'h5A;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_open_ign_start"}, 32'(bus.liberado), 1);
    bus.fechou = 1'b1;
    @(negedge clk);
    bus.fechou = 1'b0;
    check({tag, "_closed_lib"}, 32'(bus.liberado), 0);
    check({tag, "_closed_busy"}, 32'(bus.busy), 0);
    check({tag, "_closed_tent"}, 32'(bus.tentativas), 0);
    @(negedge clk);
    check({tag, "_no_queued"}, 32'(bus.busy), 0);
  endtask

  initial begin
    int n;
    rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33; rom[3] = 8'hA5;
    rom[4] = 8'h00; rom[5] = 8'h00; rom[6] = 8'h00; rom[7] = 8'h00;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.fechou = 1'b0;
    bus.senha_digitada = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // Match at entry 3, then close the door.
    run_scan(8'hA5, 0, "hit_a5");
    close_door("hit_a5");

    // Full miss; negado is a single-cycle pulse and rom_addr holds the last entry.
    run_scan(8'h5A, 0, "miss1");
    @(negedge clk);
    check("miss1_negado_drop", 32'(bus.negado), 0);
    check("miss1_rom_addr_hold", 32'(bus.rom_addr), 7);

    // Two more misses trigger the lockout; a start inside it is ignored.
    run_scan(8'h5A, 0, "miss2");
    run_scan(8'h77, 0, "miss3_lock");
    n = 0;
    while (bus.bloqueado === 1'b1 && n < 40) begin
      n++;
      bus.start = (n == 5);
      bus.senha_digitada = 8'h11;
      @(negedge clk);
    end
    bus.start = 1'b0;
    $display("lockout length=%0d", n);
    check("lock_len", 32'(n), 16);
    check("lock_end_busy", 32'(bus.busy), 0);
    check("lock_end_tent", 32'(bus.tentativas), 32'(m_tries));
    run_scan(8'h11, 0, "after_lock");
    close_door("after_lock");

    // Two misses then a hit clears the failure count.
    run_scan(8'h5A, 0, "pre1");
    run_scan(8'h5A, 0, "pre2");
    run_scan(8'h22, 0, "hit_22");
    close_door("hit_22");

    // start/fechou during FETCH and CHECK leave the scan untouched.
    run_scan(8'h33, 3, "poke_hit");
    close_door("poke_hit");
    run_scan(8'h5A, 6, "poke_miss");

    // Reset in cycle 6 of a scan, with start also high.
    bus.senha_digitada = 8'h5A;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    check_reset_vals("rst_scan");
    m_tries = 0;
    run_scan(8'hA5, 0, "rst_scan_rescan");
    close_door("rst_scan_rescan");

    // Reset in the middle of a lockout.
    run_scan(8'h5A, 0, "l2_miss1");
    run_scan(8'h5A, 0, "l2_miss2");
    run_scan(8'h5A, 0, "l2_miss3");
    repeat (5) @(negedge clk);
    check("l2_mid_lock", 32'(bus.bloqueado), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("rst_lock");
    m_tries = 0;
    run_scan(8'h11, 0, "rst_lock_rescan");
    close_door("rst_lock_rescan");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/acess_seq_ctrl.md
# acess_seq_ctrl

Access-control sequencer that owns the password ROM read port and the match decision for the door-lock subsystem. On each `start` it latches the typed password, walks the ROM entries in order, and compares each entry against the latched value. It then grants access until the door reports closed, or counts a failed attempt. After `MAX_TRIES` consecutive failures it enforces a timed lockout. It sits between the keypad/password front end and `single_port_ROM`, replacing the free-running address counter with a deterministic, handshaked scan.

## Interface
- `ADDR_W`, 3: ROM address width.
- `DATA_W`, 8: password/ROM word width.
- `N_ENTRIES`, 8: valid ROM entries scanned, addresses 0..N_ENTRIES-1; N_ENTRIES ≤ 2^ADDR_W.
- `MAX_TRIES`, 3: consecutive failures that trigger lockout; ≥1.
- `LOCK_CYCLES`, 16: lockout duration in clk cycles; ≥1.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: one-cycle request; `senha_digitada` is valid in the same cycle.
- `senha_digitada` input DATA_W: typed password.
- `fechou` input 1: door-closed indication, level.
- `rom_addr` output ADDR_W: ROM address.
- `rom_data` input DATA_W: ROM output, registered, 1-cycle read latency.
- `busy` output 1: high in any state other than IDLE.
- `liberado` output 1: access granted, level.
- `negado` output 1: one-cycle pulse per failed attempt.
- `bloqueado` output 1: lockout active, level.
- `tentativas` output $clog2(MAX_TRIES+1): consecutive failure count.

## Operation
- States: IDLE, FETCH, CHECK, OPEN, LOCKOUT.
- IDLE:
  - `start`=1 latches `senha_digitada` into `pw_q`, sets `idx`=0, goes to FETCH.
  - `start`=0 holds.
- FETCH:
  - Drives `rom_addr`=idx; goes to CHECK.
- CHECK:
  - Compares `rom_data`==`pw_q`.
  - Match goes to OPEN and clears `tentativas`.
  - Mismatch with idx<N_ENTRIES-1: idx+1, go to FETCH.
  - Mismatch with idx=N_ENTRIES-1 (fail): `tentativas`+1 and `negado` pulses.
    - New count = MAX_TRIES: go to LOCKOUT, load lock timer with LOCK_CYCLES-1.
    - Otherwise go to IDLE.
- OPEN:
  - `liberado`=1.
  - `fechou`=1 goes to IDLE, and `liberado` drops the next cycle.
- LOCKOUT:
  - `bloqueado`=1; the timer decrements each cycle.
  - At timer 0: go to IDLE, clear `tentativas`, `bloqueado` drops.
- `start` outside IDLE is ignored and not queued. This covers FETCH, CHECK, OPEN and LOCKOUT.
- `fechou` is ignored outside OPEN.
- `rom_addr` holds its last value outside FETCH/CHECK and is 0 after reset.
- The first matching entry wins; later entries are not read.
- `tentativas` saturates at MAX_TRIES and is never visible above it.

## Timing
- All outputs are registered.
- Reset values: `rom_addr`=0, `busy`=0, `liberado`=0, `negado`=0, `bloqueado`=0, `tentativas`=0. State is IDLE and `pw_q`=0.
- `rst` mid-scan, in OPEN, or in LOCKOUT returns to IDLE next cycle with all reset values. `rst` has priority over `start`/`fechou` in the same cycle.
- Cycles are numbered with the `start` sample edge as 0. Cycle n is the period after edge n.
  - FETCH i occupies cycle 2i+1; CHECK i occupies cycle 2i+2.
- Match at entry i: `liberado`=1 from cycle 2i+3.
- No match: `negado`=1 in cycle 2·N_ENTRIES+1 only (17 for defaults).
  - In that same cycle, either `busy`=0, or `bloqueado`=1 if the lockout is triggered.
- Lockout lasts exactly LOCK_CYCLES cycles with `bloqueado`=1. A `start` in the first cycle after it is accepted.
- `busy` rises in cycle 1 and covers FETCH/CHECK/OPEN/LOCKOUT.
- `fechou` sampled high in OPEN cycle m: `liberado`=0 and `busy`=0 in cycle m+1.

## Structure
- Shared package `acess_pkg`:
  - state enum `acess_state_t` (IDLE, FETCH, CHECK, OPEN, LOCKOUT);
  - default constants `ACESS_ADDR_W`=3, `ACESS_DATA_W`=8.
- The existing `comparador` is instantiated for the CHECK equality test. The ROM stays external and connects through `rom_addr`/`rom_data`.
- The lock timer is a down-counter inside this block; no separate sub-module.

## Test plan
- ROM {0:11,1:22,2:33,3:A5,4..7:00}, start with 8'hA5 → `rom_addr` sequence 0,1,2,3; `liberado` rises in cycle 9. Then `fechou`=1 → `liberado`=0 next cycle, `tentativas`=0.
- Start with 8'h5A (absent) → 8 FETCH/CHECK pairs, `negado` pulse in cycle 17 only, `tentativas`=1, `busy`=0 in cycle 17.
- Three consecutive misses → third `negado` coincides with `bloqueado`=1 for exactly 16 cycles. A `start` during lockout is ignored. Then `tentativas`=0, and `start` with 8'h11 gives `liberado` in cycle 3.
- Two misses, then start with 8'h22 → `liberado` in cycle 5 and `tentativas` cleared to 0.
- `start` pulsed during FETCH/CHECK and in OPEN, `fechou`=1 during a scan → no effect; scan result unchanged.
- `rst` asserted in cycle 6 of a scan, and again mid-LOCKOUT → next cycle all outputs at reset values, `rom_addr`=0; a subsequent `start` scans from address 0.
